// File: rtl/decode_regfile_if.sv
// Decode/operand-fetch bus: instruction handshake, ALU-facing issue fields and writeback port.
// master drives instructions and writeback; slave is the decode stage.
interface decode_regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [RAW-1:0]  rd_out;
    logic            out_valid;
    logic            wb_en;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output in_valid, instr, wb_en, wb_rd, wb_data,
        input  in_ready, opcode, funct3, funct7, in1, in2, rd_out, out_valid
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_rd, wb_data,
        output in_ready, opcode, funct3, funct7, in1, in2, rd_out, out_valid
    );
endinterface

// File: rtl/decode_regfile.sv
// RV32 decode/operand-fetch stage with register file, writeback port and RAW scoreboard.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data and lifts the stall.
module decode_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned RAW  = 5
) (
    input logic            clk,
    input logic            rst,
    decode_regfile_if.slave bus
);

`ifdef DECODE_WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    localparam logic [4:0] OpRType = 5'b01100;

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pending_q, pending_d;

    logic [4:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic [XLEN-1:0] in1_q, in2_q;
    logic [RAW-1:0]  rd_q;
    logic            out_valid_q;

    logic [RAW-1:0]  rs1, rs2, rd;
    logic [4:0]      opcode;
    logic            wb_write;
    logic            fwd1, fwd2;
    logic            stall1, stall2;
    logic            accept;
    logic            is_write;
    logic [XLEN-1:0] op1, op2;

    always_comb begin
        rs1      = bus.instr[19:15];
        rs2      = bus.instr[24:20];
        rd       = bus.instr[11:7];
        opcode   = bus.instr[6:2];
        wb_write = bus.wb_en && (bus.wb_rd != '0);

        // Forwarding only ever applies to a nonzero register being written this cycle.
        fwd1     = Bypass && wb_write && (bus.wb_rd == rs1);
        fwd2     = Bypass && wb_write && (bus.wb_rd == rs2);
        stall1   = pending_q[rs1] && !fwd1;
        stall2   = pending_q[rs2] && !fwd2;

        bus.in_ready = !(bus.in_valid && (stall1 || stall2));
        accept       = bus.in_valid && bus.in_ready;
        is_write     = (opcode == OpRType) && (rd != '0);

        // regs_q[0] is never written, so x0 always reads zero.
        op1 = fwd1 ? bus.wb_data : regs_q[rs1];
        op2 = fwd2 ? bus.wb_data : regs_q[rs2];
    end

    // Clear on writeback first so a same-edge set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_write) pending_d[bus.wb_rd] = 1'b0;
        if (accept && is_write) pending_d[rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (wb_write) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= accept;
            if (accept) begin
                opcode_q <= opcode;
                funct3_q <= bus.instr[14:12];
                funct7_q <= bus.instr[31:25];
                in1_q    <= op1;
                in2_q    <= op2;
                rd_q     <= rd;
            end
        end
    end

    assign bus.opcode    = opcode_q;
    assign bus.funct3    = funct3_q;
    assign bus.funct7    = funct7_q;
    assign bus.in1       = in1_q;
    assign bus.in2       = in2_q;
    assign bus.rd_out    = rd_q;
    assign bus.out_valid = out_valid_q;

endmodule
